// File: rtl/instruction_fetch_stage.sv
// Fetch stage and IF/ID register. It owns the PC, drives a 1-cycle synchronous-read
// instruction memory, and holds a one-entry skid buffer so that ID stalls lose nothing.
// Ports:
//   clk, reset (sync, active-high)
//   imem_req/imem_addr (comb request), imem_rdata (data for last cycle's request)
//   stall_id (ID cannot accept), redirect/redirect_pc (flush and refetch)
//   if_id_valid/if_id_instruction/if_id_pc/if_id_pc_plus4 (to decoder)
// Optional: define IFETCH_PERF_EN to add the perf_fetched and perf_stall counters.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
`ifdef IFETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall,
`endif
  output logic        if_id_valid,
  output logic [31:0] if_id_instruction,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4
);

  typedef enum logic {
    SKID_EMPTY = 1'b0,
    SKID_FULL  = 1'b1
  } skid_state_t;

  skid_state_t r_skid_state;
  skid_state_t w_skid_next;

  logic [31:0] r_fetch_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_pc;
  logic [31:0] r_pc4;

  logic        w_accept;
  logic        w_skid_full;
  logic        w_src_valid;
  logic [31:0] w_src_instr;
  logic [31:0] w_src_pc;
  logic        w_issue;
  logic [31:0] w_target;

  // Masking keeps every bit of redirect_pc in use while forcing word alignment.
  assign w_target    = redirect_pc & ~32'h3;
  assign w_skid_full = (r_skid_state == SKID_FULL);
  assign w_accept    = !r_valid || !stall_id;
  assign w_src_valid = w_skid_full || r_inflight;
  assign w_src_instr = w_skid_full ? r_skid_instr : imem_rdata;
  assign w_src_pc    = w_skid_full ? r_skid_pc : r_inflight_pc;

  always_comb begin
    w_skid_next = r_skid_state;
    if (redirect || w_accept) begin
      w_skid_next = SKID_EMPTY;
    end else if (!w_skid_full && r_inflight) begin
      w_skid_next = SKID_FULL;
    end
  end

  // A full skid means nowhere to put another response, so fetch pauses.
  always_comb begin
    w_issue   = redirect || (w_skid_next != SKID_FULL);
    imem_req  = !reset && w_issue;
    imem_addr = redirect ? w_target : r_fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_state <= SKID_EMPTY;
    end else begin
      r_skid_state <= w_skid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_skid_instr  <= 32'h0;
      r_skid_pc     <= 32'h0;
      r_valid       <= 1'b0;
      r_instr       <= 32'h0;
      r_pc          <= 32'h0;
      r_pc4         <= 32'h0;
    end else if (redirect) begin
      r_fetch_pc    <= w_target + 32'd4;
      r_inflight    <= 1'b1;
      r_inflight_pc <= w_target;
      r_valid       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_valid <= w_src_valid;
        if (w_src_valid) begin
          r_instr <= w_src_instr;
          r_pc    <= w_src_pc;
          r_pc4   <= w_src_pc + 32'd4;
        end
      end else if (!w_skid_full && r_inflight) begin
        r_skid_instr <= imem_rdata;
        r_skid_pc    <= r_inflight_pc;
      end
      if (w_issue) begin
        r_fetch_pc    <= r_fetch_pc + 32'd4;
        r_inflight_pc <= r_fetch_pc;
      end
      r_inflight <= w_issue;
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched <= 32'h0;
      r_perf_stall   <= 32'h0;
    end else begin
      if (!redirect && w_accept && w_src_valid) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (r_valid && stall_id && !redirect) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

  assign if_id_valid       = r_valid;
  assign if_id_instruction = r_instr;
  assign if_id_pc          = r_pc;
  assign if_id_pc_plus4    = r_pc4;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage.
// Memory word at address a is 0x1000_0000 + (a >> 2).
module tb_instruction_fetch_stage;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall_id;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc_plus4;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int errors = 0;
  int checks = 0;

  instruction_fetch_stage #(.RESET_PC(32'h0)) dut (
    .clk               (clk),
    .reset             (reset),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .stall_id          (stall_id),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
`ifdef IFETCH_PERF_EN
    .perf_fetched      (perf_fetched),
    .perf_stall        (perf_stall),
`endif
    .if_id_valid       (if_id_valid),
    .if_id_instruction (if_id_instruction),
    .if_id_pc          (if_id_pc),
    .if_id_pc_plus4    (if_id_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall_id = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall_id = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req got=%b exp=0", imem_req);
    end
    checks++;
    if ({if_id_valid, if_id_instruction, if_id_pc, if_id_pc_plus4} !== 97'h0) begin
      errors++;
      $display("FAIL rst_ifid got=%b %h %h %h exp=0", if_id_valid,
               if_id_instruction, if_id_pc, if_id_pc_plus4);
    end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] epc;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL seq_fetch c%0d got=%b %h exp=1 %h", k, imem_req,
                 imem_addr, 32'(4 * k));
      end
      checks++;
      if (if_id_valid !== (k >= 2)) begin
        errors++;
        $display("FAIL seq_valid c%0d got=%b exp=%b", k, if_id_valid, k >= 2);
      end
      if (k >= 2) begin
        epc = 32'(4 * (k - 2));
        checks++;
        if (if_id_pc !== epc || if_id_pc_plus4 !== epc + 32'd4 ||
            if_id_instruction !== mem_word(epc)) begin
          errors++;
          $display("FAIL seq_ifid c%0d got=%h %h %h exp=%h %h %h", k,
                   if_id_instruction, if_id_pc, if_id_pc_plus4,
                   mem_word(epc), epc, epc + 32'd4);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] epc;
    do_reset();
    repeat (4) tick();
    stall_id = 1'b1;
    for (int k = 4; k < 7; k++) begin
      if (k > 4) tick();
      @(negedge clk);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h8 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold c%0d got=%b %h req=%b exp=1 8 req=0", k,
                 if_id_valid, if_id_pc, imem_req);
      end
    end
    tick();
    stall_id = 1'b0;
    @(negedge clk);
    checks++;
    if (if_id_pc !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL stall_release got=%h %b %h exp=8 1 10", if_id_pc,
               imem_req, imem_addr);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      epc = 32'h0C + 32'(4 * k);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== epc ||
          if_id_instruction !== mem_word(epc)) begin
        errors++;
        $display("FAIL stall_drain %0d got=%b %h %h exp=1 %h %h", k,
                 if_id_valid, if_id_pc, if_id_instruction, epc, mem_word(epc));
      end
`ifdef IFETCH_PERF_EN
      if (k == 0) begin
        checks++;
        if (perf_stall !== 32'd3 || perf_fetched !== 32'd4) begin
          errors++;
          $display("FAIL perf_a got=%0d %0d exp=3 4", perf_stall, perf_fetched);
        end
      end
      if (k == 2) begin
        checks++;
        if (perf_stall !== 32'd3 || perf_fetched !== 32'd6) begin
          errors++;
          $display("FAIL perf_b got=%0d %0d exp=3 6", perf_stall, perf_fetched);
        end
      end
`endif
    end
  endtask

  task automatic test_redirect();
    logic [31:0] epc;
    do_reset();
    repeat (4) tick();
    stall_id = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_pc = 32'h43;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL redir_addr got=%b %h exp=1 40", imem_req, imem_addr);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b0 || imem_addr !== 32'h44) begin
      errors++;
      $display("FAIL redir_flush got=%b %h exp=0 44", if_id_valid, imem_addr);
    end
    tick();
    stall_id = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      epc = 32'h40 + 32'(4 * k);
      checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== epc ||
          if_id_instruction !== mem_word(epc)) begin
        errors++;
        $display("FAIL redir_seq %0d got=%b %h %h exp=1 %h %h", k,
                 if_id_valid, if_id_pc, if_id_instruction, epc, mem_word(epc));
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr);
    end
    tick();
    redirect = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_next got=%b %h exp=1 0", imem_req, imem_addr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC ||
        if_id_pc_plus4 !== 32'h0 || if_id_instruction !== 32'h4FFF_FFFF) begin
      errors++;
      $display("FAIL wrap_ifid got=%b %h %h %h exp=1 fffffffc 0 4fffffff",
               if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction);
    end
    tick();
    @(negedge clk);
    checks++;
    if (if_id_pc !== 32'h0 || if_id_instruction !== 32'h1000_0000) begin
      errors++;
      $display("FAIL wrap_after got=%h %h exp=0 10000000", if_id_pc,
               if_id_instruction);
    end
  endtask

  task automatic test_reset_midstall();
    do_reset();
    repeat (4) tick();
    stall_id = 1'b1;
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL mrst_req got=%b exp=0", imem_req);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 ||
        if_id_instruction !== 32'h0) begin
      errors++;
      $display("FAIL mrst_clear got=%b %h %h exp=0 0 0", if_id_valid,
               if_id_pc, if_id_instruction);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL mrst_restart got=%b %h exp=1 0", imem_req, imem_addr);
    end
    tick();
    stall_id = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h4 ||
        if_id_instruction !== 32'h1000_0000) begin
      errors++;
      $display("FAIL mrst_first got=%b %h %h %h exp=1 0 4 10000000",
               if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instruction);
    end
  endtask

  initial begin
    imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_midstall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
